// File: rtl/divider8.sv
// Sequential 8-bit unsigned restoring divider: one quotient bit per clock, eight steps per
// operation, with a one-cycle DONE strobe and divide-by-zero / zero-quotient flags.
module divider8 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_start,
    output logic [7:0] o_q,
    output logic [7:0] o_r,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_dz,
    output logic       o_z
);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e     r_state;
    state_e     w_state_next;
    logic [2:0] r_cnt;
    logic [7:0] r_d;
    logic [7:0] r_s;
    logic [8:0] r_p;
    logic [7:0] r_q;
    logic [7:0] r_r;
    logic       r_dz;
    logic       r_z;

    logic       w_accept;
    logic       w_b_zero;
    logic [8:0] w_t;
    logic       w_ge;
    logic [8:0] w_p_next;
    logic [7:0] w_d_next;

    // START is honoured in IDLE and FIN alike, which gives back-to-back operation.
    assign w_accept = i_start && (r_state != StRun);
    assign w_b_zero = (i_b == 8'h00);

    assign w_t      = {r_p[7:0], r_d[7]};
    assign w_ge     = (w_t >= {1'b0, r_s});
    assign w_p_next = w_ge ? (w_t - {1'b0, r_s}) : w_t;
    assign w_d_next = {r_d[6:0], w_ge};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle, StFin: begin
                if (w_accept) begin
                    w_state_next = w_b_zero ? StFin : StRun;
                end else begin
                    w_state_next = StIdle;
                end
            end
            StRun: begin
                if (r_cnt == 3'd0) begin
                    w_state_next = StFin;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        unique case (r_state)
            StRun:   o_busy = 1'b1;
            StFin:   o_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 3'd0;
            r_d   <= 8'h00;
            r_s   <= 8'h00;
            r_p   <= 9'h000;
            r_q   <= 8'h00;
            r_r   <= 8'h00;
            r_dz  <= 1'b0;
            r_z   <= 1'b0;
        end else if (w_accept) begin
            if (w_b_zero) begin
                r_q  <= 8'hFF;
                r_r  <= i_a;
                r_dz <= 1'b1;
                r_z  <= 1'b0;
            end else begin
                r_d   <= i_a;
                r_s   <= i_b;
                r_p   <= 9'h000;
                r_cnt <= 3'd7;
            end
        end else if (r_state == StRun) begin
            r_p <= w_p_next;
            r_d <= w_d_next;
            if (r_cnt == 3'd0) begin
                r_q  <= w_d_next;
                r_r  <= w_p_next[7:0];
                r_dz <= 1'b0;
                r_z  <= (w_d_next == 8'h00);
            end else begin
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

    assign o_q  = r_q;
    assign o_r  = r_r;
    assign o_dz = r_dz;
    assign o_z  = r_z;

endmodule

// File: tb/tb_divider8.sv
// Scoreboard bench for divider8: stimulus pushes expected results with their DONE cycle,
// a negedge monitor pops and compares whenever DONE is seen.
module tb_divider8;

    logic       clk;
    logic       rst_n;
    logic [7:0] i_a;
    logic [7:0] i_b;
    logic       i_start;
    logic [7:0] o_q;
    logic [7:0] o_r;
    logic       o_busy;
    logic       o_done;
    logic       o_dz;
    logic       o_z;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       z;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_cmp;
    int   n_bad;

    divider8 dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_a    (i_a),
        .i_b    (i_b),
        .i_start(i_start),
        .o_q    (o_q),
        .o_r    (o_r),
        .o_busy (o_busy),
        .o_done (o_done),
        .o_dz   (o_dz),
        .o_z    (o_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DONE must match the oldest outstanding expectation, on its cycle.
    always @(negedge clk) begin
        if (o_done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got DONE with q=%0d r=%0d expected none (cycle %0d)",
                         o_q, o_r, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result{q,r,dz,z}", {14'd0, o_q, o_r, o_dz, o_z},
                      {14'd0, e.q, e.r, e.dz, e.z});
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Issue one operation from idle and wait until its DONE cycle.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                         input logic [7:0] er, input logic edz, input logic ez);
        int nb;
        @(negedge clk);
        i_a     = a;
        i_b     = b;
        i_start = 1'b1;
        sb.push_back('{eq, er, edz, ez, cyc + 1 + ((b != 8'h00) ? 8 : 0)});
        @(negedge clk);
        i_start = 1'b0;
        i_a     = ~a;
        i_b     = 8'h00;
        if (b == 8'h00) begin
            check("busy_dz", {31'd0, o_busy}, 32'd0);
        end else begin
            nb = 0;
            for (int i = 0; i < 8; i++) begin
                if (o_busy) nb++;
                @(negedge clk);
            end
            check("busy_len", nb + (o_busy ? 100 : 0), 8);
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        i_a     = 8'h00;
        i_b     = 8'h00;
        i_start = 1'b0;
        #2;
        check("reset_state", {24'd0, o_q, o_r, o_busy, o_done, o_dz, o_z}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("hold_qr", {16'd0, o_q, o_r}, {16'd0, 8'd14, 8'd2});

        issue(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b0);
        issue(8'd5, 8'd10, 8'd0, 8'd5, 1'b0, 1'b1);
        issue(8'd0, 8'd3, 8'd0, 8'd0, 1'b0, 1'b1);
        issue(8'd200, 8'd0, 8'hFF, 8'd200, 1'b1, 1'b0);
        issue(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // START held high, operands churn during RUN; second op accepted on the DONE cycle.
        begin
            int c;
            c = cyc;
            i_a     = 8'd60;
            i_b     = 8'd8;
            i_start = 1'b1;
            sb.push_back('{8'd7, 8'd4, 1'b0, 1'b0, c + 9});
            sb.push_back('{8'd8, 8'd2, 1'b0, 1'b0, c + 18});
            for (int i = 1; i <= 8; i++) begin
                @(negedge clk);
                i_a = 8'(i * 17);
                i_b = 8'(i & 1);
            end
            @(negedge clk);
            i_a = 8'd50;
            i_b = 8'd6;
            @(negedge clk);
            i_start = 1'b0;
            i_b     = 8'd0;
            repeat (9) @(negedge clk);
        end

        // Asynchronous reset after four steps of 77/5: no DONE, outputs cleared at once.
        @(negedge clk);
        i_a     = 8'd77;
        i_b     = 8'd5;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrun_reset", {24'd0, o_q, o_r, o_busy, o_done, o_dz, o_z}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        issue(8'd77, 8'd5, 8'd15, 8'd2, 1'b0, 1'b0);

        for (int i = 0; i < 2000; i++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            issue(a, b, a / b, a % b, 1'b0, (a / b) == 8'd0);
        end

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing_done: got %0d outstanding expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
